// File: rtl/mem_stage_if.sv
// mem_stage_if: load/store request bus between the MEM stage and data memory.
// The stage is the master; the memory (or its model) is the slave.
interface mem_stage_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage with req/ack data port, timeout abort and
// MEM/WB register. Optional MISALIGN_TRAP_EN suppresses misaligned accesses.
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [1:0]  Control_i,
    input  logic [31:0] ALU_i,
    input  logic [31:0] RS2data_i,
    input  logic [4:0]  RDaddr_i,
    mem_stage_if.master mem,
    output logic        stall_o,
    output logic        err_o,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ALU_o,
    output logic [31:0] MemData_o,
    output logic [4:0]  RDaddr_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             acc;
    logic             mis;
    logic             eacc;
    logic             req;
    logic             ack;
    logic             done;
    logic             tmo;
    logic             stall;

    assign acc = MemRead_i | MemWrite_i;

`ifdef MISALIGN_TRAP_EN
    assign mis = acc & (ALU_i[1:0] != 2'b00) & (state == IDLE);
`else
    assign mis = 1'b0;
`endif

    assign eacc  = acc & ~mis;
    assign req   = ~rst_i & ((state == BUSY) | eacc);
    assign ack   = mem.mem_ack_i;
    assign done  = req & ack;
    assign tmo   = (state == BUSY) & (cnt == CNT_W'(TIMEOUT - 1)) & ~ack;
    assign stall = req & ~ack & ~tmo;

    assign mem.mem_req_o   = req;
    assign mem.mem_we_o    = ~rst_i & MemWrite_i;
    assign mem.mem_addr_o  = rst_i ? 32'h0 : {ALU_i[31:2], 2'b00};
    assign mem.mem_wdata_o = rst_i ? 32'h0 : RS2data_i;
    assign stall_o         = stall;

    // Access FSM: track an outstanding request, count wait cycles, flag timeouts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            err_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (eacc & ~ack) begin
                        state <= BUSY;
                        cnt   <= CNT_W'(1);
                    end
                end
                BUSY: begin
                    if (ack) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (tmo) begin
                        state <= IDLE;
                        cnt   <= '0;
                        err_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, zero load data on abandon.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            RegWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
            ALU_o      <= 32'h0;
            MemData_o  <= 32'h0;
            RDaddr_o   <= 5'h0;
        end else if (tmo) begin
            RegWrite_o <= 1'b0;
            MemData_o  <= 32'h0;
        end else if (stall | mis) begin
            RegWrite_o <= 1'b0;
        end else begin
            RegWrite_o <= Control_i[0];
            MemtoReg_o <= Control_i[1];
            ALU_o      <= ALU_i;
            RDaddr_o   <= RDaddr_i;
            if (done & ~MemWrite_i) begin
                MemData_o <= mem.mem_rdata_i;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    // One-cycle pulse for each suppressed misaligned access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= mis;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage.
// Stimulus pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_mem_stage;

    localparam int TO = 16;

    typedef struct {
        bit        req;
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        stall;
        bit        rw;
        bit        m2r;
        bit [31:0] alu;
        bit [31:0] md;
        bit [4:0]  rd;
        bit        err;
        bit        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [1:0]  Control_i;
    logic [31:0] ALU_i;
    logic [31:0] RS2data_i;
    logic [4:0]  RDaddr_i;
    logic        stall_o;
    logic        err_o;
    logic        RegWrite_o;
    logic        MemtoReg_o;
    logic [31:0] ALU_o;
    logic [31:0] MemData_o;
    logic [4:0]  RDaddr_o;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    mem_stage_if bus();

    mem_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .MemRead_i  (MemRead_i),
        .MemWrite_i (MemWrite_i),
        .Control_i  (Control_i),
        .ALU_i      (ALU_i),
        .RS2data_i  (RS2data_i),
        .RDaddr_i   (RDaddr_i),
        .mem        (bus),
        .stall_o    (stall_o),
        .err_o      (err_o),
`ifdef MISALIGN_TRAP_EN
        .misalign_o (misalign_o),
`endif
        .RegWrite_o (RegWrite_o),
        .MemtoReg_o (MemtoReg_o),
        .ALU_o      (ALU_o),
        .MemData_o  (MemData_o),
        .RDaddr_o   (RDaddr_o)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t expq[$];
    bit   mon_en = 0;

    // model of the MEM/WB state and sticky error
    bit        m_rw, m_m2r, m_err, m_mis;
    bit [31:0] m_alu, m_md;
    bit [4:0]  m_rd;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endfunction

    // monitor: compare handshake outputs now, MEM/WB state one edge later
    exp_t cur, prev;
    bit   have_prev = 0;
    always @(negedge clk) begin
        if (!mon_en) begin
            have_prev = 0;
        end else begin
            if (have_prev) begin
                chk("wb_regwrite", {31'b0, RegWrite_o}, {31'b0, prev.rw});
                chk("wb_memtoreg", {31'b0, MemtoReg_o}, {31'b0, prev.m2r});
                chk("wb_alu", ALU_o, prev.alu);
                chk("wb_memdata", MemData_o, prev.md);
                chk("wb_rdaddr", {27'b0, RDaddr_o}, {27'b0, prev.rd});
                chk("err", {31'b0, err_o}, {31'b0, prev.err});
`ifdef MISALIGN_TRAP_EN
                chk("misalign", {31'b0, misalign_o}, {31'b0, prev.mis});
`endif
            end
            have_prev = 0;
            if (expq.size() > 0) begin
                cur = expq.pop_front();
                chk("mem_req", {31'b0, bus.mem_req_o}, {31'b0, cur.req});
                chk("stall", {31'b0, stall_o}, {31'b0, cur.stall});
                if (cur.req) begin
                    chk("mem_we", {31'b0, bus.mem_we_o}, {31'b0, cur.we});
                    chk("mem_addr", bus.mem_addr_o, cur.addr);
                    chk("mem_wdata", bus.mem_wdata_o, cur.wdata);
                end
                prev      = cur;
                have_prev = 1;
            end
        end
    end

    // One instruction: memory acks after w wait cycles (w >= TO never acks).
    task automatic issue(input bit rd, input bit wr, input bit [1:0] ctrl,
                         input bit [31:0] alu, input bit [31:0] wd,
                         input bit [4:0] rdd, input int w,
                         input bit [31:0] rdata);
        bit   acc, mis, go, to;
        int   last;
        exp_t e;
        acc = rd | wr;
        mis = 0;
`ifdef MISALIGN_TRAP_EN
        mis = acc && (alu[1:0] != 2'b00);
`endif
        go   = acc && !mis;
        to   = go && (w > TO - 1);
        last = !go ? 0 : (to ? TO - 1 : w);
        for (int k = 0; k <= last; k++) begin
            @(posedge clk);
            #1;
            MemRead_i       = rd;
            MemWrite_i      = wr;
            Control_i       = ctrl;
            ALU_i           = alu;
            RS2data_i       = wd;
            RDaddr_i        = rdd;
            bus.mem_ack_i   = go && (k == w);
            bus.mem_rdata_i = (go && k == w) ? rdata : $urandom;
            e.req   = go;
            e.we    = wr;
            e.addr  = {alu[31:2], 2'b00};
            e.wdata = wd;
            e.stall = go && (k < last);
            if (go && k < last) begin
                m_rw = 0;
            end else if (to) begin
                m_rw  = 0;
                m_md  = 0;
                m_err = 1;
            end else if (mis) begin
                m_rw = 0;
            end else begin
                m_rw  = ctrl[0];
                m_m2r = ctrl[1];
                m_alu = alu;
                m_rd  = rdd;
                if (go && !wr) m_md = rdata;
            end
            m_mis = mis;
            e.rw  = m_rw;
            e.m2r = m_m2r;
            e.alu = m_alu;
            e.md  = m_md;
            e.rd  = m_rd;
            e.err = m_err;
            e.mis = m_mis;
            expq.push_back(e);
        end
    endtask

    task automatic drive_zero();
        MemRead_i       = 0;
        MemWrite_i      = 0;
        Control_i       = 0;
        ALU_i           = 0;
        RS2data_i       = 0;
        RDaddr_i        = 0;
        bus.mem_ack_i   = 0;
        bus.mem_rdata_i = 0;
    endtask

    task automatic model_clear();
        m_rw  = 0;
        m_m2r = 0;
        m_err = 0;
        m_mis = 0;
        m_alu = 0;
        m_md  = 0;
        m_rd  = 0;
    endtask

    initial begin
        int r, w;
        drive_zero();
        model_clear();
        rst_i     = 1;
        MemRead_i = 1;
        ALU_i     = 32'h44;
        #12;
        chk("rst_req", {31'b0, bus.mem_req_o}, 32'h0);
        chk("rst_stall", {31'b0, stall_o}, 32'h0);
        chk("rst_regwrite", {31'b0, RegWrite_o}, 32'h0);
        chk("rst_alu", ALU_o, 32'h0);
        chk("rst_memdata", MemData_o, 32'h0);
        chk("rst_err", {31'b0, err_o}, 32'h0);
        drive_zero();
        @(posedge clk);
        #1 rst_i = 0;
        mon_en = 1;

        issue(1, 0, 2'b11, 32'h40, 32'h0, 5'd5, 0, 32'hDEADBEEF);
        issue(0, 1, 2'b00, 32'h80, 32'h1234, 5'd7, 3, 32'h0);
        issue(1, 0, 2'b11, 32'h100, 32'h0, 5'd9, 99, 32'h0);
        issue(0, 0, 2'b01, 32'h55, 32'h0, 5'd3, 0, 32'h0);
        issue(1, 0, 2'b01, 32'h44, 32'h0, 5'd2, TO - 1, 32'h0BADF00D);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            if (r < 17)       w = $urandom_range(0, 5);
            else if (r == 17) w = TO - 1;
            else if (r == 18) w = TO - 2;
            else              w = 99;
            r = $urandom_range(0, 3);
            issue(r == 1 || r == 3, r == 2 || r == 3,
                  2'($urandom), $urandom, $urandom, 5'($urandom),
                  w, $urandom);
        end

        issue(0, 0, 2'b01, 32'h55, 32'h0, 5'd3, 0, 32'h0);
        repeat (2) @(negedge clk);
        #1 mon_en = 0;
        @(posedge clk);
        #1;
        MemRead_i = 1;
        Control_i = 2'b11;
        ALU_i     = 32'h200;
        RDaddr_i  = 5'd8;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_stall", {31'b0, stall_o}, 32'h1);
        chk("pre_rst_alu", ALU_o, 32'h55);
        #2 rst_i = 1;
        #1;
        chk("mid_rst_req", {31'b0, bus.mem_req_o}, 32'h0);
        chk("mid_rst_stall", {31'b0, stall_o}, 32'h0);
        chk("mid_rst_addr", bus.mem_addr_o, 32'h0);
        chk("mid_rst_alu", ALU_o, 32'h0);
        chk("mid_rst_rd", {27'b0, RDaddr_o}, 32'h0);
        chk("mid_rst_err", {31'b0, err_o}, 32'h0);
        drive_zero();
        @(posedge clk);
        #1 rst_i = 0;
        model_clear();
        mon_en = 1;

        issue(1, 0, 2'b11, 32'h60, 32'h0, 5'd4, 2, 32'hCAFEF00D);
        issue(1, 0, 2'b11, 32'h42, 32'h0, 5'd6, 0, 32'h13572468);
        issue(0, 0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("queue_drained", expq.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
